// File: rtl/aeses_core_arbiter.sv
// Two-channel front end for one aeses_core: round-robin grant, lazy key
// schedule (only on owner change or key update), then op issue and result return.
module aeses_core_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic         req0_enc_decneg_i,
  input  logic [127:0] req0_blk_i,
  input  logic [1:0]   req0_key_mode_i,
  input  logic [255:0] req0_key_i,
  input  logic         req0_key_update_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic         req1_enc_decneg_i,
  input  logic [127:0] req1_blk_i,
  input  logic [1:0]   req1_key_mode_i,
  input  logic [255:0] req1_key_i,
  input  logic         req1_key_update_i,
  output logic         resp0_valid_o,
  output logic         resp1_valid_o,
  output logic         resp_err_o,
  output logic [127:0] resp_blk_o,
  output logic         core_enable_key_schedule_o,
  output logic [1:0]   core_key_mode_o,
  output logic [255:0] core_aes_key_o,
  output logic         core_enable_op_o,
  output logic         core_enc_decneg_o,
  output logic [127:0] core_aes_blk_o,
  input  logic         core_ready_i,
  input  logic         core_valid_i,
  input  logic [127:0] core_aes_blk_i
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned KEY_W  = 256;
  localparam int unsigned MODE_W = 2;
  // Matches the KEY_INVALID code of aeses_defines.vh.
  localparam logic [MODE_W-1:0] KEY_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_ISSUE, S_KEY_WAIT, S_OP_ISSUE, S_OP_WAIT, S_RESP
  } state_t;

  typedef struct packed {
    logic [KEY_W-1:0]  key;
    logic [MODE_W-1:0] mode;
    logic [BLK_W-1:0]  blk;
    logic              enc;
    logic              id;
  } req_t;

  state_t            state, state_nxt;
  req_t              lat;
  logic              loaded_valid, loaded_owner, last_grant;
  logic [1:0]        dirty, dirty_nxt;
  logic              key_wait_first;
  logic              armed;

  logic              grant_valid, winner, need_sched, win_invalid, grant_c;
  logic [KEY_W-1:0]  win_key;
  logic [MODE_W-1:0] win_mode;
  logic [BLK_W-1:0]  win_blk;
  logic              win_enc;

  // Winner selection and schedule-need decision for the IDLE grant cycle.
  always_comb begin
    grant_valid = armed & (req0_valid_i | req1_valid_i);
    winner      = 1'b0;
    if (req0_valid_i && req1_valid_i) winner = ~last_grant;
    else if (req1_valid_i)            winner = 1'b1;
    win_key     = winner ? req1_key_i        : req0_key_i;
    win_mode    = winner ? req1_key_mode_i   : req0_key_mode_i;
    win_blk     = winner ? req1_blk_i        : req0_blk_i;
    win_enc     = winner ? req1_enc_decneg_i : req0_enc_decneg_i;
    win_invalid = (win_mode == KEY_INVALID);
    need_sched  = !loaded_valid || (loaded_owner != winner) || dirty[winner];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          if (need_sched && win_invalid) state_nxt = S_RESP;
          else if (need_sched)           state_nxt = S_KEY_ISSUE;
          else                           state_nxt = S_OP_ISSUE;
        end
      end
      S_KEY_ISSUE: if (core_ready_i)                    state_nxt = S_KEY_WAIT;
      S_KEY_WAIT:  if (!key_wait_first && core_ready_i) state_nxt = S_OP_ISSUE;
      S_OP_ISSUE:  if (core_ready_i)                    state_nxt = S_OP_WAIT;
      S_OP_WAIT:   if (core_valid_i)                    state_nxt = S_RESP;
      S_RESP:                                           state_nxt = S_IDLE;
      default:                                          state_nxt = S_IDLE;
    endcase
  end

  // Handshake strobes are decoded from the registered state.
  always_comb begin
    grant_c                    = (state == S_IDLE) && grant_valid;
    req0_ready_o               = grant_c && !winner;
    req1_ready_o               = grant_c && winner;
    core_enable_key_schedule_o = (state == S_KEY_ISSUE) && core_ready_i;
    core_enable_op_o           = (state == S_OP_ISSUE) && core_ready_i;
    resp0_valid_o              = (state == S_RESP) && !lat.id;
    resp1_valid_o              = (state == S_RESP) && lat.id;
  end

  // A key update landing on the schedule cycle of the same channel stays pending.
  always_comb begin
    dirty_nxt = dirty;
    if (core_enable_key_schedule_o) dirty_nxt[lat.id] = 1'b0;
    if (req0_key_update_i)          dirty_nxt[0] = 1'b1;
    if (req1_key_update_i)          dirty_nxt[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat            <= '0;
      loaded_valid   <= 1'b0;
      loaded_owner   <= 1'b0;
      last_grant     <= 1'b1;
      dirty          <= 2'b00;
      key_wait_first <= 1'b0;
      armed          <= 1'b0;
      resp_err_o     <= 1'b0;
      resp_blk_o     <= '0;
    end else begin
      armed          <= 1'b1;
      dirty          <= dirty_nxt;
      key_wait_first <= core_enable_key_schedule_o;
      if (grant_c) begin
        last_grant <= winner;
        lat.id     <= winner;
        lat.blk    <= win_blk;
        lat.enc    <= win_enc;
        // Key context only moves when it is about to be scheduled.
        if (need_sched && !win_invalid) begin
          lat.key  <= win_key;
          lat.mode <= win_mode;
        end
        resp_err_o <= need_sched && win_invalid;
        if (need_sched && win_invalid) resp_blk_o <= '0;
      end
      if (core_enable_key_schedule_o) begin
        loaded_valid <= 1'b1;
        loaded_owner <= lat.id;
      end
      if ((state == S_OP_WAIT) && core_valid_i) resp_blk_o <= core_aes_blk_i;
    end
  end

  assign core_aes_key_o    = lat.key;
  assign core_key_mode_o   = lat.mode;
  assign core_aes_blk_o    = lat.blk;
  assign core_enc_decneg_o = lat.enc;

endmodule

// File: tb/tb_aeses_core_arbiter.sv
// Randomized bench for aeses_core_arbiter with a behavioural core stub and a
// request-level reference model of key ownership, grants and results.
module tb_aeses_core_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid [2];
  logic         req_enc [2];
  logic [127:0] req_blk [2];
  logic [1:0]   req_mode [2];
  logic [255:0] req_key [2];
  logic         req_upd [2];
  logic         req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, resp_err_o;
  logic [127:0] resp_blk_o, core_aes_blk_o;
  logic         core_enable_key_schedule_o, core_enable_op_o, core_enc_decneg_o;
  logic [1:0]   core_key_mode_o;
  logic [255:0] core_aes_key_o;
  logic         c_ready, c_valid;
  logic [127:0] c_blk_out;

  always #5 clk = ~clk;

  aeses_core_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req_valid[0]), .req0_ready_o(req0_ready_o), .req0_enc_decneg_i(req_enc[0]),
    .req0_blk_i(req_blk[0]), .req0_key_mode_i(req_mode[0]), .req0_key_i(req_key[0]),
    .req0_key_update_i(req_upd[0]),
    .req1_valid_i(req_valid[1]), .req1_ready_o(req1_ready_o), .req1_enc_decneg_i(req_enc[1]),
    .req1_blk_i(req_blk[1]), .req1_key_mode_i(req_mode[1]), .req1_key_i(req_key[1]),
    .req1_key_update_i(req_upd[1]),
    .resp0_valid_o(resp0_valid_o), .resp1_valid_o(resp1_valid_o), .resp_err_o(resp_err_o),
    .resp_blk_o(resp_blk_o),
    .core_enable_key_schedule_o(core_enable_key_schedule_o), .core_key_mode_o(core_key_mode_o),
    .core_aes_key_o(core_aes_key_o), .core_enable_op_o(core_enable_op_o),
    .core_enc_decneg_o(core_enc_decneg_o), .core_aes_blk_o(core_aes_blk_o),
    .core_ready_i(c_ready), .core_valid_i(c_valid), .core_aes_blk_i(c_blk_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stand-in for the cipher: any function of the scheduled key exposes a wrong key.
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [1:0] m,
                                           input logic [127:0] b, input logic e);
    logic [127:0] kf;
    kf = k[255:128] ^ k[127:0] ^ {126'd0, m};
    return e ? (b ^ kf) : ({b[63:0], b[127:64]} ^ kf);
  endfunction

  // Core stub: ready stays high one cycle past an enable, inputs sampled then.
  int           c_phase, c_cnt;
  int           sched_cnt = 0;
  int           op_cnt = 0;
  logic [255:0] c_key;
  logic [1:0]   c_mode;
  logic [127:0] s_blk;
  logic         s_enc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_phase <= 0; c_cnt <= 0; c_ready <= 1'b0; c_valid <= 1'b0;
      c_blk_out <= '0; c_key <= '0; c_mode <= '0; s_blk <= '0; s_enc <= 1'b0;
    end else begin
      c_valid <= 1'b0;
      case (c_phase)
        0: begin
          if (core_enable_key_schedule_o && c_ready) begin
            c_phase <= 1; sched_cnt <= sched_cnt + 1;
          end else if (core_enable_op_o && c_ready) begin
            c_phase <= 3; op_cnt <= op_cnt + 1;
          end else begin
            c_ready <= ($urandom_range(0, 3) != 0);
          end
        end
        1: begin
          c_key <= core_aes_key_o; c_mode <= core_key_mode_o;
          c_ready <= 1'b0; c_cnt <= $urandom_range(1, 4); c_phase <= 2;
        end
        2: begin
          if (c_cnt <= 1) begin c_ready <= 1'b1; c_phase <= 0; end
          else c_cnt <= c_cnt - 1;
        end
        3: begin
          s_blk <= core_aes_blk_o; s_enc <= core_enc_decneg_o;
          c_ready <= 1'b0; c_cnt <= $urandom_range(1, 4); c_phase <= 4;
        end
        default: begin
          if (c_cnt <= 1) begin
            c_valid <= 1'b1; c_blk_out <= core_fn(c_key, c_mode, s_blk, s_enc);
            c_ready <= 1'b1; c_phase <= 0;
          end else c_cnt <= c_cnt - 1;
        end
      endcase
    end
  end

  // Reference model: what the core holds and which request is outstanding.
  bit           m_valid, m_owner, m_last, m_pending, m_ch, exp_err, exp_sched;
  bit [1:0]     m_dirty;
  logic [255:0] m_key;
  logic [1:0]   m_mode;
  logic [127:0] exp_blk;
  int           m_sched_base;
  int           resp_cnt = 0;
  bit           acc [2];
  int           grants[$];
  logic [255:0] snap_key;
  logic [1:0]   snap_mode;
  logic [127:0] snap_blk;
  logic         snap_enc;

  task automatic model_reset();
    m_valid = 0; m_owner = 0; m_last = 1; m_pending = 0; m_dirty = 2'b00;
    m_key = '0; m_mode = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_enable_key_schedule_o) begin
        check("ks_when_ready", 256'(c_ready), 256'(1));
        check("ks_op_excl", 256'(core_enable_op_o), 256'(0));
        snap_key = core_aes_key_o; snap_mode = core_key_mode_o;
        if (m_pending) m_dirty[m_ch] = 1'b0;
      end
      if (core_enable_op_o) begin
        check("op_when_ready", 256'(c_ready), 256'(1));
        snap_blk = core_aes_blk_o; snap_enc = core_enc_decneg_o;
      end
      if (c_phase == 1) check("key_hold", {core_aes_key_o[255:2], core_aes_key_o[1:0] ^ core_key_mode_o},
                              {snap_key[255:2], snap_key[1:0] ^ snap_mode});
      if (c_phase == 3) check("blk_hold", 256'({core_enc_decneg_o, core_aes_blk_o}), 256'({snap_enc, snap_blk}));
      if (req_upd[0]) m_dirty[0] = 1'b1;
      if (req_upd[1]) m_dirty[1] = 1'b1;
      if (req0_ready_o || req1_ready_o) begin
        bit g, need;
        check("grant_single", 256'(req0_ready_o & req1_ready_o), 256'(0));
        check("grant_no_busy", 256'(m_pending), 256'(0));
        g = req1_ready_o;
        check("grant_rr", 256'(g), 256'((req_valid[0] && req_valid[1]) ? !m_last : req_valid[1]));
        grants.push_back(int'(g));
        acc[g] = 1;
        need = !m_valid || (m_owner != g) || m_dirty[g];
        m_last = g; m_pending = 1; m_ch = g; m_sched_base = sched_cnt;
        exp_err = need && (req_mode[g] == 2'b11);
        exp_sched = need && !exp_err;
        if (exp_sched) begin
          m_valid = 1; m_owner = g; m_key = req_key[g]; m_mode = req_mode[g];
        end
        exp_blk = core_fn(m_key, m_mode, req_blk[g], req_enc[g]);
      end
      if (resp0_valid_o || resp1_valid_o) begin
        check("resp_expected", 256'(m_pending), 256'(1));
        check("resp_single", 256'(resp0_valid_o & resp1_valid_o), 256'(0));
        if (m_pending) begin
          check("resp_chan", 256'(resp1_valid_o), 256'(m_ch));
          check("resp_err", 256'(resp_err_o), 256'(exp_err));
          check("sched_count", 256'(sched_cnt - m_sched_base), 256'(exp_sched));
          if (!exp_err) check("resp_blk", 256'(resp_blk_o), 256'(exp_blk));
        end
        m_pending = 0;
        resp_cnt++;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_strobes"}, 256'({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o,
                                   resp_err_o, core_enable_key_schedule_o, core_enable_op_o}), 256'(0));
    check({tag, "_blks"}, 256'({resp_blk_o, core_aes_blk_o}), 256'(0));
    check({tag, "_key"}, core_aes_key_o, 256'(0));
    check({tag, "_ctl"}, 256'({core_key_mode_o, core_enc_decneg_o}), 256'(0));
  endtask

  task automatic set_req(input int ch, input logic [255:0] k, input logic [1:0] m,
                         input logic [127:0] b, input logic e);
    req_key[ch] = k; req_mode[ch] = m; req_blk[ch] = b; req_enc[ch] = e;
  endtask

  task automatic run_pair(input bit v0, input bit v1);
    int want, start, cyc;
    want = int'(v0) + int'(v1);
    start = resp_cnt; acc[0] = 0; acc[1] = 0; cyc = 0;
    @(posedge clk); #1;
    req_valid[0] = v0; req_valid[1] = v1;
    while ((resp_cnt - start) < want && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (acc[0]) req_valid[0] = 0;
      if (acc[1]) req_valid[1] = 0;
    end
    req_valid[0] = 0; req_valid[1] = 0;
    if (cyc >= 400) check("req_timeout", 256'(resp_cnt - start), 256'(want));
  endtask

  task automatic pulse_upd(input int ch);
    @(posedge clk); #1; req_upd[ch] = 1;
    @(posedge clk); #1; req_upd[ch] = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  logic [255:0] k128, k256, key_pool [4];
  logic [127:0] pt;
  int           base, base_op, rc;
  bit           seen;

  initial begin
    for (int c = 0; c < 2; c++) begin
      req_valid[c] = 0; req_upd[c] = 0; set_req(c, '0, 2'b00, '0, 1'b0);
    end
    k128 = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
    k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    pt   = 128'h00112233445566778899aabbccddeeff;
    for (int i = 0; i < 4; i++)
      key_pool[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
    do_reset();

    // Cold start, repeat, then owner changes.
    base = sched_cnt;
    set_req(0, k128, 2'b00, pt, 1'b1); run_pair(1, 0);
    check("cold_sched", 256'(sched_cnt - base), 256'(1));
    run_pair(1, 0);
    check("repeat_no_sched", 256'(sched_cnt - base), 256'(1));
    set_req(1, k256, 2'b10, pt, 1'b0); run_pair(0, 1);
    run_pair(1, 0);
    check("swap_sched", 256'(sched_cnt - base), 256'(3));

    // Both channels held: grants must alternate, every grant reschedules.
    grants.delete(); base = sched_cnt;
    run_pair(1, 1); run_pair(1, 1);
    check("rr_grants", 256'(grants.size()), 256'(4));
    for (int i = 1; i < grants.size(); i++) check("rr_alt", 256'(grants[i]), 256'(1 - grants[i-1]));
    check("rr_sched", 256'(sched_cnt - base), 256'(4));

    // Key update forces a reschedule, also when it lands on the schedule cycle.
    run_pair(1, 0);
    base = sched_cnt; pulse_upd(0); run_pair(1, 0);
    check("upd_sched", 256'(sched_cnt - base), 256'(1));
    pulse_upd(0); seen = 0;
    fork
      run_pair(1, 0);
      begin
        for (int i = 0; i < 100 && !seen; i++) begin
          @(posedge clk); #1;
          if (core_enable_key_schedule_o) begin
            seen = 1; req_upd[0] = 1;
            @(posedge clk); #1; req_upd[0] = 0;
          end
        end
      end
    join
    check("upd_inject_seen", 256'(seen), 256'(1));
    base = sched_cnt; run_pair(1, 0);
    check("upd_on_issue_sched", 256'(sched_cnt - base), 256'(1));

    // Cold invalid mode: error response, core untouched.
    do_reset();
    base = sched_cnt; base_op = op_cnt;
    set_req(1, k256, 2'b11, pt, 1'b1); run_pair(0, 1);
    check("inv_no_core", 256'((sched_cnt - base) + (op_cnt - base_op)), 256'(0));

    // Reset in OP_WAIT drops the request and forgets the loaded key.
    set_req(0, k128, 2'b00, pt, 1'b1);
    acc[0] = 0; rc = resp_cnt; seen = 0;
    @(posedge clk); #1; req_valid[0] = 1;
    for (int i = 0; i < 50 && !acc[0]; i++) begin @(posedge clk); #1; end
    req_valid[0] = 0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = core_enable_op_o; end
    check("midop_op_seen", 256'(seen), 256'(1));
    @(posedge clk); #1;
    rst_n = 0; model_reset(); req_valid[1] = 1;
    #1 check_zero("midop_reset");
    @(negedge clk); req_valid[1] = 0;
    @(negedge clk); rst_n = 1;
    repeat (10) @(negedge clk);
    check("midop_no_resp", 256'(resp_cnt - rc), 256'(0));
    base = sched_cnt; run_pair(1, 0);
    check("midop_resched", 256'(sched_cnt - base), 256'(1));

    // Random traffic against the model.
    for (int it = 0; it < 80; it++) begin
      int r;
      if ($urandom_range(0, 4) == 0) pulse_upd(int'($urandom_range(0, 1)));
      for (int c = 0; c < 2; c++)
        set_req(c, key_pool[$urandom_range(0, 3)],
                ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                {$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
      r = $urandom_range(1, 3);
      run_pair(r[0], r[1]);
    end
    repeat (5) @(negedge clk);
    check("end_idle", 256'(m_pending), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
